// File: rtl/axi4_dram_responder_if.sv
// axi4_dram_responder_if
//   AXI4 bus between the DRAM controller master and the DRAM responder.
//   Signal names keep the full s_axi_* form of the slave port list.
//   modport slave  : responder side (AW/W/AR inputs, B/R outputs, readies out)
//   modport master : controller side (mirror of slave)
interface axi4_dram_responder_if #(
  parameter int AXI_ADDR_WIDTH   = 39,
  parameter int AXI_DATA_WIDTH   = 512,
  parameter int AXI_STROBE_WIDTH = AXI_DATA_WIDTH >> 3
);
  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic [15:0]                 s_axi_awid;
  logic [1:0]                  s_axi_awburst;
  logic [2:0]                  s_axi_awsize;
  logic [7:0]                  s_axi_awlen;
  logic [15:0]                 s_axi_awuser;
  logic                        s_axi_awvalid;
  logic                        s_axi_awready;
  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata;
  logic [AXI_STROBE_WIDTH-1:0] s_axi_wstrb;
  logic                        s_axi_wlast;
  logic                        s_axi_wvalid;
  logic                        s_axi_wready;
  logic [15:0]                 s_axi_bid;
  logic [1:0]                  s_axi_bresp;
  logic                        s_axi_bvalid;
  logic                        s_axi_bready;
  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr;
  logic [15:0]                 s_axi_arid;
  logic [1:0]                  s_axi_arburst;
  logic [2:0]                  s_axi_arsize;
  logic [7:0]                  s_axi_arlen;
  logic [15:0]                 s_axi_aruser;
  logic                        s_axi_arvalid;
  logic                        s_axi_arready;
  logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata;
  logic [15:0]                 s_axi_rid;
  logic [1:0]                  s_axi_rresp;
  logic                        s_axi_rlast;
  logic                        s_axi_rvalid;
  logic                        s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awid, s_axi_awburst, s_axi_awsize, s_axi_awlen, s_axi_awuser, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_araddr, s_axi_arid, s_axi_arburst, s_axi_arsize, s_axi_arlen, s_axi_aruser, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready
  );

  modport master (
    output s_axi_awaddr, s_axi_awid, s_axi_awburst, s_axi_awsize, s_axi_awlen, s_axi_awuser, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_araddr, s_axi_arid, s_axi_arburst, s_axi_arsize, s_axi_arlen, s_axi_aruser, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready
  );
endinterface

// File: rtl/axi4_dram_responder.sv
// axi4_dram_responder
//   AXI4 slave standing in for the PS DDR port on the Image2DRAM path.
//   Independent write (AW/W/B) and read (AR/R) FSMs share one byte-enabled
//   memory of MEM_DEPTH words. FIXED/INCR bursts only, AxSIZE must equal
//   AXI_STROBE_LEN; anything else answers SLVERR for the whole transaction.
//   Beats past the end of the array answer SLVERR and never alias.
// Ports:
//   s_axi_aclk    clock
//   s_axi_aresetn asynchronous active-low reset (memory contents survive)
//   axi           AXI4 slave modport (axi4_dram_responder_if)
// Build option:
//   AXI_SLAVE_BACKPRESSURE_EN - LFSR-driven random stalls on awready, wready,
//   arready and on non-first read beats.
module axi4_dram_responder #(
  parameter int AXI_ADDR_WIDTH   = 39,
  parameter int AXI_DATA_WIDTH   = 512,
  parameter int AXI_STROBE_WIDTH = AXI_DATA_WIDTH >> 3,
  parameter int AXI_STROBE_LEN   = $clog2(AXI_STROBE_WIDTH),
  parameter int MEM_DEPTH        = 1024
) (
  input logic                  s_axi_aclk,
  input logic                  s_axi_aresetn,
  axi4_dram_responder_if.slave axi
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
  localparam addr_t      BEAT_INC    = addr_t'(AXI_STROBE_WIDTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic in_rng(input addr_t a);
    return (a >> AXI_STROBE_LEN) < addr_t'(MEM_DEPTH);
  endfunction
  function automatic logic [IDX_W-1:0] widx(input addr_t a);
    return a[AXI_STROBE_LEN +: IDX_W];
  endfunction
  function automatic logic cfg_err(input logic [1:0] burst, input logic [2:0] size);
    return burst[1] || (size != 3'(AXI_STROBE_LEN));
  endfunction

  logic acc_gate, rnext_ok;
`ifdef AXI_SLAVE_BACKPRESSURE_EN
  // Galois LFSR x^8+x^6+x^5+x^4+1, right-shifting form.
  logic [7:0] lfsr;
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) lfsr <= 8'hA5;
    else                lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
  assign acc_gate = lfsr[0];
  assign rnext_ok = lfsr[1];
`else
  assign acc_gate = 1'b1;
  assign rnext_ok = 1'b1;
`endif

  logic unused_user;
  assign unused_user = ^{axi.s_axi_awuser, axi.s_axi_aruser};

  // ---------------- write channel ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t   w_state;
  logic       aw_rdy_q, w_rdy_q, bvalid_q, w_fixed, w_err, w_bad;
  logic [1:0] bresp_q;
  logic [15:0] bid_q, w_id;
  logic [7:0] w_len, w_beat;
  addr_t      w_addr;

  logic aw_hs, w_hs, w_last_beat, w_oor, w_beat_bad, w_we;
  assign axi.s_axi_awready = aw_rdy_q & acc_gate;
  assign axi.s_axi_wready  = w_rdy_q & acc_gate;
  assign axi.s_axi_bvalid  = bvalid_q;
  assign axi.s_axi_bresp   = bresp_q;
  assign axi.s_axi_bid     = bid_q;
  assign aw_hs       = axi.s_axi_awvalid & axi.s_axi_awready;
  assign w_hs        = axi.s_axi_wvalid & axi.s_axi_wready;
  assign w_last_beat = (w_beat == w_len);
  assign w_oor       = !in_rng(w_addr);
  // wlast is only checked, never trusted: termination is by beat count.
  assign w_beat_bad  = (axi.s_axi_wlast != w_last_beat) || w_oor;
  assign w_we        = w_hs & !w_err & !w_oor;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state <= W_IDLE; aw_rdy_q <= 1'b0; w_rdy_q <= 1'b0; bvalid_q <= 1'b0;
      bresp_q <= RESP_OKAY; bid_q <= '0; w_id <= '0; w_len <= '0; w_beat <= '0;
      w_addr <= '0; w_fixed <= 1'b0; w_err <= 1'b0; w_bad <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            w_addr  <= axi.s_axi_awaddr;
            w_len   <= axi.s_axi_awlen;
            w_id    <= axi.s_axi_awid;
            w_fixed <= (axi.s_axi_awburst == 2'b00);
            w_err   <= cfg_err(axi.s_axi_awburst, axi.s_axi_awsize);
            w_beat  <= '0;
            w_bad   <= 1'b0;
            aw_rdy_q <= 1'b0;
            w_rdy_q  <= 1'b1;
            w_state  <= W_DATA;
          end else begin
            aw_rdy_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_beat <= w_beat + 8'd1;
            if (!w_fixed) w_addr <= w_addr + BEAT_INC;
            if (w_beat_bad) w_bad <= 1'b1;
            if (w_last_beat) begin
              w_rdy_q  <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= w_id;
              bresp_q  <= (w_err || w_bad || w_beat_bad) ? RESP_SLVERR : RESP_OKAY;
              w_state  <= W_RESP;
            end
          end
        end
        W_RESP: begin
          // awready comes back one cycle after W_IDLE is re-entered
          if (axi.s_axi_bready) begin
            bvalid_q <= 1'b0;
            w_state  <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (w_we)
      for (int b = 0; b < AXI_STROBE_WIDTH; b++)
        if (axi.s_axi_wstrb[b]) mem[widx(w_addr)][b*8 +: 8] <= axi.s_axi_wdata[b*8 +: 8];
  end

  // ---------------- read channel ----------------
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  r_state_t   r_state;
  logic       ar_rdy_q, rvalid_q, rlast_q, r_fixed, r_err;
  logic [1:0] rresp_q;
  logic [15:0] rid_q;
  logic [7:0] r_len, r_beat;
  addr_t      r_addr;               // address of the next beat to load
  logic [AXI_DATA_WIDTH-1:0] rdata_q;

  logic ar_hs, ar_err, ar_bad, r_bad, r_hs, r_load;
  logic [AXI_DATA_WIDTH-1:0] ar_data, r_nxt_data;
  assign axi.s_axi_arready = ar_rdy_q & acc_gate;
  assign axi.s_axi_rvalid  = rvalid_q;
  assign axi.s_axi_rlast   = rlast_q;
  assign axi.s_axi_rresp   = rresp_q;
  assign axi.s_axi_rid     = rid_q;
  assign axi.s_axi_rdata   = rdata_q;
  assign ar_hs      = axi.s_axi_arvalid & axi.s_axi_arready;
  assign ar_err     = cfg_err(axi.s_axi_arburst, axi.s_axi_arsize);
  assign ar_bad     = ar_err || !in_rng(axi.s_axi_araddr);
  assign ar_data    = ar_bad ? '0 : mem[widx(axi.s_axi_araddr)];
  assign r_bad      = r_err || !in_rng(r_addr);
  assign r_nxt_data = r_bad ? '0 : mem[widx(r_addr)];
  assign r_hs       = rvalid_q & axi.s_axi_rready;
  // next beat is due after a non-final handshake, or while a stalled beat is pending
  assign r_load     = (r_hs && !rlast_q) || !rvalid_q;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state <= R_IDLE; ar_rdy_q <= 1'b0; rvalid_q <= 1'b0; rlast_q <= 1'b0;
      rresp_q <= RESP_OKAY; rid_q <= '0; rdata_q <= '0; r_len <= '0; r_beat <= '0;
      r_addr <= '0; r_fixed <= 1'b0; r_err <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_fixed  <= (axi.s_axi_arburst == 2'b00);
            r_err    <= ar_err;
            r_len    <= axi.s_axi_arlen;
            r_beat   <= '0;
            r_addr   <= (axi.s_axi_arburst == 2'b00) ? axi.s_axi_araddr : axi.s_axi_araddr + BEAT_INC;
            rdata_q  <= ar_data;
            rresp_q  <= ar_bad ? RESP_SLVERR : RESP_OKAY;
            rid_q    <= axi.s_axi_arid;
            rlast_q  <= (axi.s_axi_arlen == 8'd0);
            rvalid_q <= 1'b1;
            ar_rdy_q <= 1'b0;
            r_state  <= R_DATA;
          end else begin
            ar_rdy_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_hs && rlast_q) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            r_state  <= R_IDLE;
          end else if (r_load) begin
            if (rnext_ok) begin
              rdata_q  <= r_nxt_data;
              rresp_q  <= r_bad ? RESP_SLVERR : RESP_OKAY;
              rlast_q  <= (8'(r_beat + 8'd1) == r_len);
              r_beat   <= r_beat + 8'd1;
              if (!r_fixed) r_addr <= r_addr + BEAT_INC;
              rvalid_q <= 1'b1;
            end else begin
              rvalid_q <= 1'b0;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_dram_responder.sv
// tb_axi4_dram_responder
//   Directed stimulus with hand-computed expectations pushed into B/R
//   scoreboard queues; independent monitors pop and compare on handshakes.
module tb_axi4_dram_responder;
  localparam int AW = 39, DW = 512, SW = 64, MD = 1024;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axi4_dram_responder_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) axi ();
  axi4_dram_responder #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .MEM_DEPTH(MD)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .axi(axi));

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { logic [15:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [DW-1:0] data; logic [15:0] id; logic [1:0] resp; logic last; } r_exp_t;
  b_exp_t bq[$];
  r_exp_t rq[$];
  int     r_hs_cyc[$];

  logic [DW-1:0] wbeat [256];
  logic [SW-1:0] wst   [256];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++; n_fail++;
    $display("FAIL %s: got no handshake expected handshake within bound", name);
  endtask

  // ---------------- monitors ----------------
  b_exp_t be;
  always @(negedge clk) begin
    if (rst_n && axi.s_axi_bvalid && axi.s_axi_bready) begin
      if (bq.size() == 0) timeout("b_unexpected");
      else begin
        be = bq.pop_front();
        check("bid", DW'(axi.s_axi_bid), DW'(be.id));
        check("bresp", DW'(axi.s_axi_bresp), DW'(be.resp));
      end
    end
  end

  r_exp_t re;
  always @(negedge clk) begin
    if (rst_n && axi.s_axi_rvalid && axi.s_axi_rready) begin
      r_hs_cyc.push_back(cyc);
      if (rq.size() == 0) timeout("r_unexpected");
      else begin
        re = rq.pop_front();
        check("rdata", axi.s_axi_rdata, re.data);
        check("rid", DW'(axi.s_axi_rid), DW'(re.id));
        check("rresp", DW'(axi.s_axi_rresp), DW'(re.resp));
        check("rlast", DW'(axi.s_axi_rlast), DW'(re.last));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    axi.s_axi_awaddr = '0; axi.s_axi_awid = '0; axi.s_axi_awburst = 2'b01; axi.s_axi_awsize = 3'd6;
    axi.s_axi_awlen = '0; axi.s_axi_awuser = 16'hFFFF; axi.s_axi_awvalid = 1'b0;
    axi.s_axi_wdata = '0; axi.s_axi_wstrb = '0; axi.s_axi_wlast = 1'b0; axi.s_axi_wvalid = 1'b0;
    axi.s_axi_bready = 1'b1;
    axi.s_axi_araddr = '0; axi.s_axi_arid = '0; axi.s_axi_arburst = 2'b01; axi.s_axi_arsize = 3'd6;
    axi.s_axi_arlen = '0; axi.s_axi_aruser = 16'hFFFF; axi.s_axi_arvalid = 1'b0;
    axi.s_axi_rready = 1'b1;
  endtask

  task automatic push_r(input logic [DW-1:0] d, input logic [15:0] id, input logic [1:0] resp, input logic last);
    r_exp_t e;
    e.data = d; e.id = id; e.resp = resp; e.last = last;
    rq.push_back(e);
  endtask

  task automatic write_burst(input logic [AW-1:0] addr, input logic [15:0] id, input int len,
                             input logic [1:0] burst, input logic [2:0] size, input int bad_last,
                             input logic [1:0] exp_resp, input bit chk_lat);
    b_exp_t e;
    int t;
    e.id = id; e.resp = exp_resp;
    bq.push_back(e);
    axi.s_axi_awaddr = addr; axi.s_axi_awid = id; axi.s_axi_awlen = 8'(len);
    axi.s_axi_awburst = burst; axi.s_axi_awsize = size; axi.s_axi_awvalid = 1'b1;
    for (t = 0; t < 200; t++) begin @(negedge clk); if (axi.s_axi_awready) break; end
    if (t == 200) timeout("aw_handshake");
    @(posedge clk); #1 axi.s_axi_awvalid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      axi.s_axi_wdata = wbeat[k]; axi.s_axi_wstrb = wst[k];
      axi.s_axi_wlast = (bad_last >= 0) ? (k == bad_last) : (k == len);
      axi.s_axi_wvalid = 1'b1;
      for (t = 0; t < 200; t++) begin @(negedge clk); if (axi.s_axi_wready) break; end
      if (t == 200) timeout("w_handshake");
      @(posedge clk); #1;
    end
    axi.s_axi_wvalid = 1'b0; axi.s_axi_wlast = 1'b0;
    if (chk_lat) check("b_latency", DW'(axi.s_axi_bvalid), DW'(1));
  endtask

  task automatic read_burst(input logic [AW-1:0] addr, input logic [15:0] id, input int len,
                            input logic [1:0] burst, input logic [2:0] size, input bit chk_lat);
    int t;
    axi.s_axi_araddr = addr; axi.s_axi_arid = id; axi.s_axi_arlen = 8'(len);
    axi.s_axi_arburst = burst; axi.s_axi_arsize = size; axi.s_axi_arvalid = 1'b1;
    for (t = 0; t < 200; t++) begin @(negedge clk); if (axi.s_axi_arready) break; end
    if (t == 200) timeout("ar_handshake");
    @(posedge clk); #1 axi.s_axi_arvalid = 1'b0;
    if (chk_lat) check("r_latency", DW'(axi.s_axi_rvalid), DW'(1));
  endtask

  task automatic drain();
    int t;
    for (t = 0; t < 500; t++) begin
      @(posedge clk);
      if (bq.size() == 0 && rq.size() == 0) break;
    end
    if (t == 500) timeout("scoreboard_drain");
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] all_outs();
    return DW'({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready, axi.s_axi_bvalid,
                axi.s_axi_bresp, axi.s_axi_bid, axi.s_axi_rvalid, axi.s_axi_rlast,
                axi.s_axi_rresp, axi.s_axi_rid}) | axi.s_axi_rdata;
  endfunction

  localparam logic [DW-1:0] D0 = {16{32'hDEADBEEF}};
  localparam logic [DW-1:0] DE = {8{64'h0123456789ABCDEF}};

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] ones, part;
    int t;
    ones = '1;
    part = {{(DW-32){1'b1}}, 32'h0};
    rst_n = 1'b1;
    idle_inputs();
    #2 rst_n = 1'b0;
    #10 check("reset_outputs", all_outs(), '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 check("arready_before_edge", DW'(axi.s_axi_arready), DW'(0));
    @(posedge clk); #1;
    check("awready_after_reset", DW'(axi.s_axi_awready), DW'(1));
    check("arready_after_reset", DW'(axi.s_axi_arready), DW'(1));

    // single-beat write + read back
    wbeat[0] = D0; wst[0] = '1;
    write_burst(39'h40, 16'h1234, 0, 2'b01, 3'd6, -1, 2'b00, 1'b1);
    drain();
    push_r(D0, 16'h0055, 2'b00, 1'b1);
    read_burst(39'h40, 16'h0055, 0, 2'b01, 3'd6, 1'b1);
    drain();

    // 8-beat INCR burst, continuous rready must give back-to-back beats
    for (int k = 0; k < 8; k++) begin wbeat[k] = DW'(k); wst[k] = '1; end
    write_burst(39'h1000, 16'h0007, 7, 2'b01, 3'd6, -1, 2'b00, 1'b1);
    drain();
    for (int k = 0; k < 8; k++) push_r(DW'(k), 16'h0A0A, 2'b00, k == 7);
    r_hs_cyc.delete();
    read_burst(39'h1000, 16'h0A0A, 7, 2'b01, 3'd6, 1'b1);
    drain();
    check("burst_beats", DW'(r_hs_cyc.size()), DW'(8));
    if (r_hs_cyc.size() == 8) check("burst_no_gaps", DW'(r_hs_cyc[7] - r_hs_cyc[0]), DW'(7));

    // partial strobe: clear bytes 0-3 of an all-ones word
    wbeat[0] = ones; wst[0] = '1;
    write_burst(39'h2000, 16'h0002, 0, 2'b01, 3'd6, -1, 2'b00, 1'b0);
    wbeat[0] = '0; wst[0] = 64'h0F;
    write_burst(39'h2000, 16'h0003, 0, 2'b01, 3'd6, -1, 2'b00, 1'b0);
    drain();
    push_r(part, 16'h0004, 2'b00, 1'b1);
    read_burst(39'h2000, 16'h0004, 0, 2'b01, 3'd6, 1'b0);
    drain();

    // WRAP burst is rejected and must not touch memory
    wbeat[0] = '0; wst[0] = '1;
    write_burst(39'h40, 16'h0BAD, 0, 2'b10, 3'd6, -1, 2'b10, 1'b0);
    drain();
    push_r(D0, 16'h0005, 2'b00, 1'b1);
    read_burst(39'h40, 16'h0005, 0, 2'b01, 3'd6, 1'b0);
    drain();

    // last word of the array, then one beat past it
    wbeat[0] = DE; wst[0] = '1;
    write_burst(AW'(MD*64-64), 16'h00EE, 0, 2'b01, 3'd6, -1, 2'b00, 1'b0);
    drain();
    push_r(DE, 16'h00E1, 2'b00, 1'b0);
    push_r('0, 16'h00E1, 2'b10, 1'b1);
    read_burst(AW'(MD*64-64), 16'h00E1, 1, 2'b01, 3'd6, 1'b0);
    drain();

    // early wlast on beat 2 of a 4-beat burst
    for (int k = 0; k < 4; k++) begin wbeat[k] = DW'(k + 16); wst[k] = '1; end
    write_burst(39'h3000, 16'h0033, 3, 2'b01, 3'd6, 2, 2'b10, 1'b0);
    drain();

    // bready stalled 10 cycles on a bad-size write: B must stay put
    axi.s_axi_bready = 1'b0;
    wbeat[0] = '0; wst[0] = '1;
    write_burst(39'h40, 16'h0B0B, 0, 2'b01, 3'd5, -1, 2'b10, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("b_hold_valid", DW'(axi.s_axi_bvalid), DW'(1));
      check("b_hold_resp", DW'(axi.s_axi_bresp), DW'(2'b10));
    end
    axi.s_axi_bready = 1'b1;
    drain();

    // reset while beat 3 of an 8-beat read is on the bus
    for (int k = 0; k < 3; k++) push_r(DW'(k), 16'h0C0C, 2'b00, 1'b0);
    r_hs_cyc.delete();
    read_burst(39'h1000, 16'h0C0C, 7, 2'b01, 3'd6, 1'b0);
    for (t = 0; t < 50; t++) begin @(negedge clk); #1; if (r_hs_cyc.size() == 3) break; end
    if (t == 50) timeout("beat2_handshake");
    @(posedge clk); #1;
    check("beat3_presented", axi.s_axi_rdata, DW'(3));
    rst_n = 1'b0;
    #1 check("mid_burst_reset_outputs", all_outs(), '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 check("arready_before_edge2", DW'(axi.s_axi_arready), DW'(0));
    @(posedge clk); #1;
    check("arready_after_reset2", DW'(axi.s_axi_arready), DW'(1));
    check("scoreboard_after_reset", DW'(rq.size()), DW'(0));
    rq.delete();

    // memory kept its contents across reset
    push_r(DW'(3), 16'h0D0D, 2'b00, 1'b1);
    read_burst(39'h10C0, 16'h0D0D, 0, 2'b01, 3'd6, 1'b1);
    drain();
    push_r(D0, 16'h0D0E, 2'b00, 1'b1);
    read_burst(39'h40, 16'h0D0E, 0, 2'b01, 3'd6, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
